// File: rtl/limit_pkg.sv
// Shared float32 helpers for the limit monitor: total-order compare keys and NaN detection.
package limit_pkg;

    localparam int FLT_W = 32;

    function automatic logic f32_is_nan(input logic [FLT_W-1:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != '0);
    endfunction

    // Map sign-magnitude to an unsigned key whose order matches float order; -0 folds onto +0.
    function automatic logic [FLT_W-1:0] f32_key(input logic [FLT_W-1:0] x);
        logic [FLT_W-1:0] c;
        c = (x == 32'h8000_0000) ? '0 : x;
        return c[31] ? ~c : (c | 32'h8000_0000);
    endfunction

    function automatic logic f32_gt(input logic [FLT_W-1:0] a, input logic [FLT_W-1:0] b);
        return f32_key(a) > f32_key(b);
    endfunction

endpackage

// File: rtl/limit_ch.sv
// One monitored channel: registered float compares, over/under debounce counters and fault latches.
module limit_ch
    import limit_pkg::*;
#(
    parameter int DEB_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [FLT_W-1:0] i_data,
    input  logic             i_valid,
    input  logic [FLT_W-1:0] i_over_sp,
    input  logic [FLT_W-1:0] i_under_sp,
    input  logic             i_over_en,
    input  logic             i_under_en,
    input  logic [DEB_W-1:0] i_deb_cnt,
    input  logic             i_clr,
    output logic             o_over_flt,
    output logic             o_under_flt,
    output logic             o_over_trip,
    output logic             o_under_trip
);

    // Index 0 is the over limit, index 1 the under limit.
    logic                  vld_p1;
    logic [1:0]            viol_p1;
    logic [1:0]            en;
    logic [1:0]            trip;
    logic [1:0]            flt_p2;
    logic [1:0]            flt_nxt;
    logic [1:0][DEB_W-1:0] cnt_p2;
    logic [1:0][DEB_W-1:0] cnt_inc;
    logic [1:0][DEB_W-1:0] cnt_nxt;
    logic [DEB_W-1:0]      thresh;
    logic                  nan;

    function automatic logic [DEB_W-1:0] sat_inc(input logic [DEB_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign nan = f32_is_nan(i_data);
    assign en  = {i_under_en, i_over_en};

    // Stage 1: compare results and sample strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p1  <= 1'b0;
            viol_p1 <= '0;
        end else begin
            vld_p1     <= i_valid;
            viol_p1[0] <= nan | f32_gt(i_data, i_over_sp);
            viol_p1[1] <= nan | f32_gt(i_under_sp, i_data);
        end
    end

    always_comb begin
        thresh = (i_deb_cnt == '0) ? DEB_W'(1) : i_deb_cnt;
        for (int j = 0; j < 2; j++) begin
            cnt_inc[j] = sat_inc(cnt_p2[j]);
            trip[j]    = vld_p1 && en[j] && viol_p1[j] && (cnt_inc[j] >= thresh);
            cnt_nxt[j] = cnt_p2[j];
            if (vld_p1)
                cnt_nxt[j] = (en[j] && viol_p1[j]) ? cnt_inc[j] : '0;
            // A trip coinciding with a clear wins: fault stays, count parks at threshold.
            if (i_clr)
                cnt_nxt[j] = trip[j] ? thresh : '0;
            flt_nxt[j] = i_clr ? trip[j] : (flt_p2[j] | trip[j]);
        end
    end

    // Stage 2: debounce counters and fault latches
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_p2 <= '0;
            flt_p2 <= '0;
        end else begin
            cnt_p2 <= cnt_nxt;
            flt_p2 <= flt_nxt;
        end
    end

    assign o_over_flt   = flt_p2[0];
    assign o_under_flt  = flt_p2[1];
    assign o_over_trip  = trip[0];
    assign o_under_trip = trip[1];

endmodule

// File: rtl/limit_mon_multi.sv
// Multi-channel float32 limit monitor: per-channel debounced faults, interlock OR and first-fault capture.
module limit_mon_multi
    import limit_pkg::*;
#(
    parameter int CH    = 4,
    parameter int DEB_W = 8,
    localparam int FCW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CH*FLT_W-1:0] i_data,
    input  logic                i_valid,
    input  logic [CH*FLT_W-1:0] i_over_sp,
    input  logic [CH*FLT_W-1:0] i_under_sp,
    input  logic [CH-1:0]       i_over_en,
    input  logic [CH-1:0]       i_under_en,
    input  logic [DEB_W-1:0]    i_deb_cnt,
    input  logic                i_clr,
    output logic [CH-1:0]       o_over_flt,
    output logic [CH-1:0]       o_under_flt,
    output logic                o_intl,
    output logic [FCW-1:0]      o_first_ch,
    output logic                o_first_vld
);

    logic [CH-1:0]  over_trip;
    logic [CH-1:0]  under_trip;
    logic           cap_hit;
    logic [FCW-1:0] cap_idx;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        limit_ch #(.DEB_W(DEB_W)) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_data      (i_data[k*FLT_W +: FLT_W]),
            .i_valid     (i_valid),
            .i_over_sp   (i_over_sp[k*FLT_W +: FLT_W]),
            .i_under_sp  (i_under_sp[k*FLT_W +: FLT_W]),
            .i_over_en   (i_over_en[k]),
            .i_under_en  (i_under_en[k]),
            .i_deb_cnt   (i_deb_cnt),
            .i_clr       (i_clr),
            .o_over_flt  (o_over_flt[k]),
            .o_under_flt (o_under_flt[k]),
            .o_over_trip (over_trip[k]),
            .o_under_trip(under_trip[k])
        );
    end

    // Lowest channel with a trip this cycle wins the first-fault slot.
    always_comb begin
        cap_hit = 1'b0;
        cap_idx = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (over_trip[k] || under_trip[k]) begin
                cap_hit = 1'b1;
                cap_idx = FCW'(k);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_intl      <= 1'b0;
            o_first_vld <= 1'b0;
            o_first_ch  <= '0;
        end else begin
            o_intl <= i_clr ? (|{over_trip, under_trip})
                            : (|{o_over_flt, o_under_flt, over_trip, under_trip});
            if ((!o_first_vld || i_clr) && cap_hit) begin
                o_first_vld <= 1'b1;
                o_first_ch  <= cap_idx;
            end else if (i_clr) begin
                o_first_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_limit_mon_multi.sv
// Directed bench for limit_mon_multi (CH=4, DEB_W=8) with hand-computed expectations.
module tb_limit_mon_multi;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  d   [4];
    logic [31:0]  osp [4];
    logic [31:0]  usp [4];
    logic         valid;
    logic [3:0]   over_en, under_en;
    logic [7:0]   deb;
    logic         clr;
    logic [3:0]   over_flt, under_flt;
    logic         intl;
    logic [1:0]   first_ch;
    logic         first_vld;
    logic [127:0] data_bus, osp_bus, usp_bus;

    int n_pass  = 0;
    int n_total = 0;

    assign data_bus = {d[3], d[2], d[1], d[0]};
    assign osp_bus  = {osp[3], osp[2], osp[1], osp[0]};
    assign usp_bus  = {usp[3], usp[2], usp[1], usp[0]};

    always #5 clk = ~clk;

    limit_mon_multi #(.CH(4), .DEB_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_data     (data_bus),
        .i_valid    (valid),
        .i_over_sp  (osp_bus),
        .i_under_sp (usp_bus),
        .i_over_en  (over_en),
        .i_under_en (under_en),
        .i_deb_cnt  (deb),
        .i_clr      (clr),
        .o_over_flt (over_flt),
        .o_under_flt(under_flt),
        .o_intl     (intl),
        .o_first_ch (first_ch),
        .o_first_vld(first_vld)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One valid sample, then one idle cycle: result of the sample is visible on return.
    task automatic send();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; clr = 1'b0; deb = 8'd1;
        over_en = '0; under_en = '0;
        for (int k = 0; k < 4; k++) begin
            d[k] = 32'h0; osp[k] = 32'h7f80_0000; usp[k] = 32'hff80_0000;
        end
        tick(); tick();
        chk("rst_over",  {28'h0, over_flt},  32'h0);
        chk("rst_under", {28'h0, under_flt}, 32'h0);
        chk("rst_intl",  {31'h0, intl},      32'h0);
        chk("rst_fvld",  {31'h0, first_vld}, 32'h0);
        chk("rst_fch",   {30'h0, first_ch},  32'h0);
        rst = 1'b0;
        tick();

        // Single over trip with deb=1, two-cycle latency
        osp[0] = 32'h3f00_0000; over_en = 4'b0001; d[0] = 32'h3f4c_cccd;
        valid = 1'b1; tick(); valid = 1'b0;
        chk("t1_early", {28'h0, over_flt}, 32'h0);
        tick();
        chk("t1_over", {28'h0, over_flt}, 32'h1);
        chk("t1_intl", {31'h0, intl}, 32'h1);
        chk("t1_fvld", {31'h0, first_vld}, 32'h1);
        chk("t1_fch",  {30'h0, first_ch}, 32'h0);
        d[0] = 32'h0; send();
        chk("t1_latched", {28'h0, over_flt}, 32'h1);
        pulse_clr();
        chk("clr_over", {28'h0, over_flt}, 32'h0);
        chk("clr_intl", {31'h0, intl}, 32'h0);
        chk("clr_fvld", {31'h0, first_vld}, 32'h0);

        // Under debounce of 3 with a non-violating sample breaking the run
        deb = 8'd3; usp[1] = 32'h3e99_999a; under_en = 4'b0010;
        d[1] = 32'h0; send(); send();
        chk("t2_two_zeros", {28'h0, under_flt}, 32'h0);
        d[1] = 32'h3f99_999a; send();
        d[1] = 32'h0; send(); send();
        chk("t2_fifth", {28'h0, under_flt}, 32'h0);
        valid = 1'b1; tick(); valid = 1'b0;
        chk("t2_sixth_early", {28'h0, under_flt}, 32'h0);
        tick();
        chk("t2_sixth", {28'h0, under_flt}, 32'h2);
        chk("t2_fch", {30'h0, first_ch}, 32'h1);
        chk("t2_over_quiet", {28'h0, over_flt}, 32'h0);

        // Clear coinciding with the sample that completes the count
        pulse_clr();
        chk("t3_cleared", {28'h0, under_flt}, 32'h0);
        send(); send();
        chk("t3_partial", {28'h0, under_flt}, 32'h0);
        valid = 1'b1; tick(); valid = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        chk("t3_trip_wins", {28'h0, under_flt}, 32'h2);
        chk("t3_intl", {31'h0, intl}, 32'h1);
        under_en = 4'b0000; send();
        chk("t3_en_off_keeps", {28'h0, under_flt}, 32'h2);
        pulse_clr();

        // Simultaneous ch2/ch3 trips, then a later ch0 trip
        deb = 8'd1; osp[2] = 32'h3f00_0000; osp[3] = 32'h3f00_0000;
        over_en = 4'b1101; d[2] = 32'h3f80_0000; d[3] = 32'h3f80_0000;
        send();
        chk("t4_over", {28'h0, over_flt}, 32'hc);
        chk("t4_fch",  {30'h0, first_ch}, 32'h2);
        d[0] = 32'h3f80_0000; send();
        chk("t4_over_b", {28'h0, over_flt}, 32'hd);
        chk("t4_fch_b",  {30'h0, first_ch}, 32'h2);
        over_en = 4'b0000;
        for (int k = 0; k < 4; k++) d[k] = 32'h0;
        pulse_clr();

        // NaN fails safe only on enabled limits
        osp[1] = 32'h3f80_0000; usp[1] = 32'hbf80_0000;
        over_en = 4'b0010; under_en = 4'b0010;
        d[1] = 32'h7fc0_0000; d[2] = 32'h7fc0_0000;
        send();
        chk("t5_over",  {28'h0, over_flt},  32'h2);
        chk("t5_under", {28'h0, under_flt}, 32'h2);
        over_en = 4'b0000; under_en = 4'b0000;
        d[1] = 32'h0; d[2] = 32'h0;
        pulse_clr();

        // Signed zero equality, negative ordering, deb=0 acting as 1, live setpoint change
        deb = 8'd0; osp[0] = 32'h0; usp[0] = 32'h0;
        over_en = 4'b0001; under_en = 4'b0001; d[0] = 32'h8000_0000;
        send();
        chk("t6_negzero_over",  {28'h0, over_flt},  32'h0);
        chk("t6_negzero_under", {28'h0, under_flt}, 32'h0);
        under_en = 4'b0000; osp[0] = 32'hbf80_0000; d[0] = 32'hc000_0000;
        send();
        chk("t6_neg_below", {28'h0, over_flt}, 32'h0);
        d[0] = 32'hbf00_0000; send();
        chk("t6_neg_above", {28'h0, over_flt}, 32'h1);
        pulse_clr();

        // Reset mid-debounce discards the partial count
        deb = 8'd3; osp[0] = 32'h3f00_0000; d[0] = 32'h3f80_0000;
        send(); send();
        rst = 1'b1; #2; rst = 1'b0;
        send(); send();
        chk("t7_after_rst", {28'h0, over_flt}, 32'h0);
        send();
        chk("t7_trip", {28'h0, over_flt}, 32'h1);

        // Asynchronous reset clears latched state without a clock edge
        #2; rst = 1'b1; #1;
        chk("t8_async_over", {28'h0, over_flt}, 32'h0);
        chk("t8_async_intl", {31'h0, intl}, 32'h0);
        chk("t8_async_fvld", {31'h0, first_vld}, 32'h0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/limit_mon_multi.md
LIMIT_MON_MULTI -- requirements
Module: limit_mon_multi

Interface
REQ-001 SHALL have parameter CH, default 4, number of monitored channels (1..16).
REQ-002 SHALL have parameter DEB_W, default 8, width of the debounce count.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_data  input  CH*32  IEEE-754 single-precision samples, channel k at bits [32k+31:32k].
REQ-006 SHALL have port i_valid  input  1  sample strobe, qualifying all channels of i_data in that cycle.
REQ-007 SHALL have port i_over_sp  input  CH*32  per-channel over setpoint (float32).
REQ-008 SHALL have port i_under_sp  input  CH*32  per-channel under setpoint (float32).
REQ-009 SHALL have port i_over_en  input  CH  per-channel over-limit enable.
REQ-010 SHALL have port i_under_en  input  CH  per-channel under-limit enable.
REQ-011 SHALL have port i_deb_cnt  input  DEB_W  count of consecutive violating valid samples needed to trip; 0 is treated as 1.
REQ-012 SHALL have port i_clr  input  1  one-cycle pulse that clears latched faults.
REQ-013 SHALL have port o_over_flt  output  CH  latched over-limit faults.
REQ-014 SHALL have port o_under_flt  output  CH  latched under-limit faults.
REQ-015 SHALL have port o_intl  output  1  OR of all bits of o_over_flt and o_under_flt.
REQ-016 SHALL have port o_first_ch  output  max(1,$clog2(CH))  index of the first channel to trip.
REQ-017 SHALL have port o_first_vld  output  1  o_first_ch holds a valid index.

Function
REQ-018 Over violation: data > over_sp, strict, in true float ordering; +0 and -0 compare equal.
REQ-019 Under violation: data < under_sp, strict.
REQ-020 A NaN data value SHALL count as a violation of every enabled limit on that channel, so the monitor fails safe.
REQ-021 Stage 1 SHALL register the compare results and i_valid. Stage 2 SHALL update the counters and latches. A fault is visible 2 cycles after the i_valid sample that completes the count.
REQ-022 Each channel SHALL hold independent over and under saturating counters. Each counter updates only on a stage-1 valid.
REQ-023 A counter SHALL increment on a violating valid sample whose limit is enabled. It SHALL reset to 0 on a non-violating valid sample or when its enable is low.
REQ-024 When a counter reaches max(i_deb_cnt,1), the matching fault bit SHALL set and stay set until cleared.
REQ-025 Deasserting an enable SHALL NOT clear an already latched fault.
REQ-026 i_clr SHALL zero all fault bits and counters, and SHALL clear o_first_vld.
REQ-027 Simultaneous i_clr and a trip on the same channel: the trip wins; the fault bit stays set and the counter is held at its threshold.
REQ-028 o_first_ch/o_first_vld SHALL capture on the first cycle any fault sets while o_first_vld=0. Ties go to the lowest channel index, and over takes precedence within a channel.
REQ-029 o_intl SHALL be registered, asserting in the same cycle as the fault bit.
REQ-030 Changing a setpoint mid-run SHALL take effect on the next valid sample and SHALL NOT reset the counters.

Reset
REQ-031 i_rst asserted SHALL immediately zero all counters, pipeline registers, o_over_flt, o_under_flt, o_intl, o_first_ch and o_first_vld.
REQ-032 Reset asserted mid-debounce SHALL discard the partial count; counting restarts from 0 after release.

Structure
REQ-033 Package limit_pkg SHALL hold the float32 ordered-compare function (sign-magnitude to ordered key, NaN detect) and the FLT_W=32 constant.
REQ-034 Sub-module limit_ch SHALL implement one channel (compare, two counters, two latches). It SHALL be instantiated CH times by generate.
REQ-035 The top level SHALL hold only the generate loop, the first-fault capture and the o_intl OR.

Verification
REQ-036 CH=4, deb=1, ch0 over_sp=3f000000 (0.5), en; one valid sample 3f4ccccd (0.8) -> o_over_flt[0]=1, o_intl=1 two cycles later, o_first_ch=0.
REQ-037 deb=3, ch1 under_sp=3e99999a (0.3), en; valid samples 0,0,3f99999a,0,0,0 -> no trip after the first two zeros; trip 2 cycles after the sixth sample.
REQ-038 Latched fault, then data back to 0 and i_clr pulse -> all faults 0 and o_first_vld=0. Same pulse coinciding with a completing violation -> fault remains 1.
REQ-039 ch2 and ch3 trip in the same cycle -> o_first_ch=2. A later ch0 trip -> o_first_ch unchanged.
REQ-040 Data 7fc00000 (NaN) on a channel with both limits enabled -> both fault bits set. The same NaN on a channel with both limits disabled -> no fault.
REQ-041 i_rst pulsed after 2 of 3 violating samples, then 2 more violating samples -> no trip; a third violating sample -> trip.
